// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle control stage around a combinational 32-bit array divider.
// Latches DIV operands, drives the divider with unsigned magnitudes, waits a fixed
// settle window, then sign-corrects quotient/remainder into LO/HI with a done pulse.
// Divide-by-zero and signed overflow (0x80000000 / -1) bypass the divider entirely.
//
// Build option: define DIV_SIGN_FIXUP_EN for signed support; when undefined, in_signed
// is ignored, operands/results pass raw and the signed-overflow bypass is removed.
//
// Ports:
//   in_clk, in_rst_n                 clock, async active-low reset
//   in_start, in_signed              request (sampled in idle) and signedness
//   in_dividend, in_divisor          operands, sampled with in_start
//   out_busy, out_done               not-idle flag, one-cycle completion pulse
//   out_div_zero                     last completed op had a zero divisor
//   out_lo, out_hi                   quotient / remainder registers
//   out_div_dividend/out_div_divisor magnitudes driven to the divider
//   in_div_quotient/in_div_remainder unsigned divider results
module div_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_start,
  input  logic        in_signed,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic        out_busy,
  output logic        out_done,
  output logic        out_div_zero,
  output logic [31:0] out_lo,
  output logic [31:0] out_hi,
  output logic [31:0] out_div_dividend,
  output logic [31:0] out_div_divisor,
  input  logic [31:0] in_div_quotient,
  input  logic [31:0] in_div_remainder
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StSettle, StFixup} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        zero_q, zero_d;      // div-zero flag of the op in flight
  logic [31:0] raw_q_q, raw_q_d;
  logic [31:0] raw_r_q, raw_r_d;
  logic [31:0] dd_q, dd_d;
  logic [31:0] dv_q, dv_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        div_zero_q, div_zero_d;
  logic        done_q, done_d;

  // Operand decode, evaluated on the raw inputs for the idle-state start.
  logic        a_neg, b_neg, ovf;
`ifdef DIV_SIGN_FIXUP_EN
  assign a_neg = in_signed & in_dividend[31];
  assign b_neg = in_signed & in_divisor[31];
  assign ovf   = in_signed && (in_dividend == 32'h8000_0000) && (in_divisor == 32'hFFFF_FFFF);
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign ovf   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    zero_d     = zero_q;
    raw_q_d    = raw_q_q;
    raw_r_d    = raw_r_q;
    dd_d       = dd_q;
    dv_d       = dv_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_start) begin
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dd_d    = a_neg ? (32'd0 - in_dividend) : in_dividend;
          dv_d    = b_neg ? (32'd0 - in_divisor) : in_divisor;
          zero_d  = 1'b0;
          if (in_divisor == 32'd0) begin
            // Bypass results are staged as raw values with no sign correction.
            raw_q_d = 32'hFFFF_FFFF;
            raw_r_d = in_dividend;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            zero_d  = 1'b1;
            state_d = StFixup;
          end else if (ovf) begin
            raw_q_d = 32'h8000_0000;
            raw_r_d = 32'd0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = StFixup;
          end else begin
            cnt_d   = 4'(SETTLE_CYCLES - 1);
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          raw_q_d = in_div_quotient;
          raw_r_d = in_div_remainder;
          state_d = StFixup;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StFixup: begin
        lo_d       = q_neg_q ? (32'd0 - raw_q_q) : raw_q_q;
        hi_d       = r_neg_q ? (32'd0 - raw_r_q) : raw_r_q;
        div_zero_d = zero_q;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      zero_q     <= 1'b0;
      raw_q_q    <= 32'd0;
      raw_r_q    <= 32'd0;
      dd_q       <= 32'd0;
      dv_q       <= 32'd0;
      lo_q       <= 32'd0;
      hi_q       <= 32'd0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      zero_q     <= zero_d;
      raw_q_q    <= raw_q_d;
      raw_r_q    <= raw_r_d;
      dd_q       <= dd_d;
      dv_q       <= dv_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign out_busy         = (state_q != StIdle);
  assign out_done         = done_q;
  assign out_div_zero     = div_zero_q;
  assign out_lo           = lo_q;
  assign out_hi           = hi_q;
  assign out_div_dividend = dd_q;
  assign out_div_divisor  = dv_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scoreboard queue filled by the stimulus,
// drained by a monitor on out_done. Includes a divider model whose outputs are
// wrong until the operands have been stable for the settle window.
module tb_div_sequencer;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] lo, hi, dd, dv;
  logic [31:0] quo, rem;

  div_sequencer #(.SETTLE_CYCLES(S)) dut (
    .in_clk          (clk),
    .in_rst_n        (rst_n),
    .in_start        (start),
    .in_signed       (sgn),
    .in_dividend     (dividend),
    .in_divisor      (divisor),
    .out_busy        (busy),
    .out_done        (done),
    .out_div_zero    (div_zero),
    .out_lo          (lo),
    .out_hi          (hi),
    .out_div_dividend(dd),
    .out_div_divisor (dv),
    .in_div_quotient (quo),
    .in_div_remainder(rem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: garbage until operands have been stable long enough.
  logic [63:0] prev_ops = '0;
  int          age = 100;
  always @(posedge clk) begin
    prev_ops <= {dd, dv};
    if ({dd, dv} != prev_ops) age <= 0;
    else if (age < 100) age <= age + 1;
  end
  logic [31:0] q_true, r_true;
  always_comb begin
    q_true = (dv == 32'd0) ? 32'hFFFF_FFFF : dd / dv;
    r_true = (dv == 32'd0) ? dd : dd % dv;
    quo = (age >= S - 2) ? q_true : ~q_true;
    rem = (age >= S - 2) ? r_true : ~r_true;
  end

  typedef struct {
    logic [31:0] lo, hi, md, mv;
    logic        dz;
    int          lat;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t model(input bit s_in, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
`ifdef DIV_SIGN_FIXUP_EN
    bit s = s_in;
`else
    bit s = 1'b0;
`endif
    e.dz  = 1'b0;
    e.lat = S + 1;
    e.cyc = 0;
    e.md  = (s && a[31]) ? -a : a;
    e.mv  = (s && b[31]) ? -b : b;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1; e.lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000; e.hi = 32'd0; e.lat = 1;
    end else if (s) begin
      e.lo = $signed(a) / $signed(b);
      e.hi = $signed(a) % $signed(b);
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest expected result, at the expected cycle.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
        check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        check("done_cycle", cyc, e.cyc);
        check("div_dividend_stable", dd, e.md);
        check("div_divisor_stable", dv, e.mv);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge (plus extra cycles).
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input int extra);
    exp_t e;
    int   w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
    start = 1'b1; sgn = s; dividend = a; divisor = b;
    e = model(s, a, b);
    e.cyc = cyc + e.lat + 1;
    sb.push_back(e);
    @(negedge clk);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < extra; i++) begin
      start = 1'b1; sgn = $urandom_range(0, 1); dividend = $urandom; divisor = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_lo"}, lo, 32'd0);
    check({tag, "_hi"}, hi, 32'd0);
    check({tag, "_dz"}, {31'd0, div_zero}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_dd"}, dd, 32'd0);
    check({tag, "_dv"}, dv, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zeroed("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b1, 32'd30, 32'd4, 0);
    do_op(1'b1, 32'd10, 32'hFFFF_FFFD, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'h10, 3);
    do_op(1'b0, 32'd5, 32'd0, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Reset mid-settle: op aborted, nothing reported.
    do_op(1'b1, 32'd30, 32'd4, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zeroed("mid_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_zeroed("post_reset");
    do_op(1'b1, 32'd30, 32'd4, 0);

    for (int n = 0; n < 40; n++) begin
      bit          s = $urandom_range(0, 1);
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      int          k = $urandom_range(0, 9);
      if (k == 0) b = 32'd0;
      else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (k <= 4) begin
        b = $urandom_range(1, 20);
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      do_op(s, a, b, 0);
    end

    begin
      int w = 0;
      while (sb.size() != 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("drain", sb.size(), 32'd0);
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
